seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Receive-side counterpart to the multiplexed 4-digit 7-segment display driver. It samples the one-hot digit-select and active-high segment lines, decodes each segment pattern back to a BCD digit, checks that the scan order is legal, and reassembles each complete frame into a binary value. It drives on-chip loopback self-check of the row-count display path and the bench's display scoreboard.

## Interface
Parameters:
- SEG_LAG, default 1: cycles by which seg_data_i trails its digit_i select (the driver registers segments one cycle after the select); legal values 0 or 1.
- ERR_CNT_W, default 8: width of the saturating error counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- digit_i  in  4  one-hot digit select: 1000 = thousands, 0100 = hundreds, 0010 = tens, 0001 = units; 0000 = blank gap.
- seg_data_i  in  7  active-high segments; bit0 = a … bit6 = g.
- value_o  out  14  last good frame value, 0..9999.
- valid_o  out  1  one-cycle pulse when value_o is updated.
- changed_o  out  1  one-cycle pulse with valid_o when the new value differs from the previous value_o.
- frame_err_o  out  1  one-cycle pulse on an illegal scan order.
- seg_err_o  out  1  one-cycle pulse on an undecodable segment pattern.
- err_cnt_o  out  ERR_CNT_W  saturating count of dropped frames.

## Operation
- Pairing:
  - digit_i is delayed SEG_LAG cycles internally to give digit_d.
  - Each cycle pairs digit_d with the current seg_data_i.
- Segment decode, pattern to digit:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - Any other pattern under a non-zero digit_d is invalid.
- FSM states: IDLE, EXP_H, EXP_T, EXP_U.
  - IDLE: wait for digit_d = 1000 with a valid pattern, then acc ← d and go to EXP_H.
  - EXP_H: on 0100, acc ← acc*10 + d, go to EXP_T.
  - EXP_T: on 0010, acc ← acc*10 + d, go to EXP_U.
  - EXP_U: on 0001, value_o ← acc*10 + d, pulse valid_o, go to IDLE.
  - In any state, digit_d = 0000 is ignored and the state is held.
- Arithmetic:
  - acc is 14 bits; acc*10 is computed as (acc<<3)+(acc<<1).
  - No overflow is possible: maximum 9999.
- Errors:
  - Unexpected one-hot code, or non-one-hot non-zero digit_d: pulse frame_err_o.
  - Invalid pattern: pulse seg_err_o.
  - Both pulse in the same cycle if both conditions hold.
  - Either error drops the partial frame, increments err_cnt_o (saturating at all-ones; one increment per dropped frame) and returns to IDLE.
  - Resync: if the offending code is 1000 with a valid pattern, go directly to EXP_H with acc ← d, in the same cycle the error is flagged.
- 1000 received in IDLE is a normal frame start, not an error.
- A code arriving in IDLE other than 1000 or 0000 is silently ignored: no error, no count.
- changed_o compares the new value against the registered value_o; the first frame after reset compares against 0.

## Timing
- Reset values: all outputs 0, state IDLE, acc 0, digit delay line 0.
- Reset mid-frame discards the partial frame. The first frame after rst deasserts must start at a thousands select.
- Latency: with the units (digit_d, seg) pair present at cycle t, value_o, valid_o and changed_o are registered and visible at t+1.
- With SEG_LAG = 1, the driver's units select at cycle t-1 therefore yields valid_o at t+1.
- frame_err_o, seg_err_o and err_cnt_o update at t+1 for an offending pair at t.
- Steady state: one valid_o per 5-cycle scan frame. There is no handshake; results that are not consumed are overwritten.

## Structure
- Package seg7_pkg holds:
  - the ten segment-code localparams;
  - the digit one-hot constants DIG_TH, DIG_HU, DIG_TE, DIG_UN and DIG_NONE;
  - the FSM state typedef.
- The display driver shares the same package.
- Sub-module seg7_pattern_decode is purely combinational: it maps 7-bit pattern to a 4-bit digit plus a valid bit.
- The top level holds the delay line, FSM, accumulator and counters.

## Test plan
- Driver-style stream for 1234 (patterns 06, 5B, 4F, 66), SEG_LAG = 1 → value_o = 1234 with valid_o and changed_o pulsing at units + 1; a repeated frame gives valid_o = 1, changed_o = 0.
- Order 1000, 0100, 0001 (tens skipped) → frame_err_o pulse, no valid_o, err_cnt_o = 1; a following correct frame of 0042 → value_o = 42.
- Tens pattern 7'h00 → seg_err_o pulse, frame dropped, value_o unchanged; 300 consecutive bad frames → err_cnt_o saturates at 255.
- rst asserted after the hundreds pair → all outputs 0 next cycle; a later 0007 frame → value_o = 7, changed_o = 1.
- Frames 9999 then 0000 → value_o = 14'h270F then 0, changed_o pulsing both times.
- SEG_LAG = 0 build with aligned digit/segment stimulus for 0999 → value_o = 999; a mid-frame 1000 → frame_err_o and immediate resync, so the next units completes the new frame.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment display path: segment codes,
// one-hot digit selects and the scan decoder FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [3:0] DIG_TH   = 4'b1000;
  localparam logic [3:0] DIG_HU   = 4'b0100;
  localparam logic [3:0] DIG_TE   = 4'b0010;
  localparam logic [3:0] DIG_UN   = 4'b0001;
  localparam logic [3:0] DIG_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXP_H = 2'd1,
    ST_EXP_T = 2'd2,
    ST_EXP_U = 2'd3
  } scan_state_t;

  // Shift-and-add multiply; operands never exceed 999 so 14 bits cannot overflow.
  function automatic logic [13:0] times10(input logic [13:0] a);
    return (a << 3) + (a << 1);
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display scan bus: one-hot digit select plus active-high segments.
// No handshake: the master drives every cycle and the slave samples every cycle.
interface seg7_scan_decoder_if;
  logic [3:0] digit_i;
  logic [6:0] seg_data_i;

  modport master (output digit_i, output seg_data_i);
  modport slave  (input  digit_i, input  seg_data_i);
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational map from a 7-segment pattern back to its BCD digit.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 4-digit display scan, checks scan order and segment
// patterns, and reassembles each complete frame into a binary value.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SEG_LAG   = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_decoder_if.slave   scan,
  output logic [13:0]          value_o,
  output logic                 valid_o,
  output logic                 changed_o,
  output logic                 frame_err_o,
  output logic                 seg_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output scan_state_t          dbg_state
);

  logic [3:0]  digit_d;
  logic [3:0]  pat_digit;
  logic        pat_valid;
  logic [3:0]  exp_code;
  logic [13:0] acc;
  logic [13:0] acc_next;
  scan_state_t state;

  // Realign the select with the segments, which the driver registers later.
  generate
    if (SEG_LAG == 0) begin : g_no_lag
      assign digit_d = scan.digit_i;
    end else begin : g_lag
      logic [3:0] digit_q;
      always_ff @(posedge clk) begin
        if (rst) digit_q <= DIG_NONE;
        else     digit_q <= scan.digit_i;
      end
      assign digit_d = digit_q;
    end
  endgenerate

  seg7_pattern_decode u_decode (
    .pattern (scan.seg_data_i),
    .digit   (pat_digit),
    .valid   (pat_valid)
  );

  always_comb begin
    exp_code = DIG_TH;
    case (state)
      ST_IDLE:  exp_code = DIG_TH;
      ST_EXP_H: exp_code = DIG_HU;
      ST_EXP_T: exp_code = DIG_TE;
      ST_EXP_U: exp_code = DIG_UN;
      default:  exp_code = DIG_TH;
    endcase
  end

  assign acc_next  = times10(acc) + {10'd0, pat_digit};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc         <= '0;
      value_o     <= '0;
      valid_o     <= 1'b0;
      changed_o   <= 1'b0;
      frame_err_o <= 1'b0;
      seg_err_o   <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      valid_o     <= 1'b0;
      changed_o   <= 1'b0;
      frame_err_o <= 1'b0;
      seg_err_o   <= 1'b0;
      if (digit_d != DIG_NONE) begin
        if (state == ST_IDLE) begin
          // Only a thousands select can open a frame; anything else is noise.
          if (digit_d == DIG_TH) begin
            if (pat_valid) begin
              acc   <= {10'd0, pat_digit};
              state <= ST_EXP_H;
            end else begin
              seg_err_o <= 1'b1;
              if (!(&err_cnt_o)) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
            end
          end
        end else if (digit_d == exp_code && pat_valid) begin
          if (state == ST_EXP_U) begin
            value_o   <= acc_next;
            valid_o   <= 1'b1;
            changed_o <= (acc_next != value_o);
            state     <= ST_IDLE;
          end else begin
            acc   <= acc_next;
            state <= (state == ST_EXP_H) ? ST_EXP_T : ST_EXP_U;
          end
        end else begin
          frame_err_o <= (digit_d != exp_code);
          seg_err_o   <= !pat_valid;
          if (!(&err_cnt_o)) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
          // A clean thousands pair restarts the frame instead of being lost.
          if (digit_d == DIG_TH && pat_valid) begin
            acc   <= {10'd0, pat_digit};
            state <= ST_EXP_H;
          end else begin
            state <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule
